// File: rtl/sr_sched_pkg.sv
// Package shared by the SR flag scheduler slice.
//   state_e     : sweep controller states (idle / clearing sweep)
//   OP_SET/RESET: encoding of the per-requester req_set bit
//   op_to_level : flag level written by a set/reset command
package sr_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Level stored into a flag for a given op (S=1,R=0 -> 1; S=0,R=1 -> 0)
  function automatic logic op_to_level(input logic op);
    logic level;
    case (op)
      OP_SET:   level = 1'b1;
      OP_RESET: level = 1'b0;
      default:  level = 1'b0;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/sr_flag_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Ports:
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  PTR_W    highest-priority requester this cycle
//   grant     out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx out PTR_W    index of the granted requester
//   any_grant out 1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Scan from rr_ptr upward with wrap; scanning offsets high-to-low lets the
  // smallest offset (closest to the pointer) overwrite and win.
  always_comb begin
    int cand;
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {PTR_W{1'b0}};
    any_grant = 1'b0;
    cand      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[cand]) begin
        grant_idx = PTR_W'(cand);
        any_grant = 1'b1;
      end else begin
        grant_idx = grant_idx;
      end
    end
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/sr_flag_scheduler.sv
// SR flag bank shared by NUM_REQ requesters through a round-robin arbiter,
// with a serialized one-flag-per-cycle clear sweep.
// Optional build macro: SR_CONFLICT_DETECT_EN enables sticky detection of
// simultaneous opposite commands to the same in-range flag (S=R=1).
// Ports:
//   clk, rst (sync, active high)
//   req_valid/req_set/req_idx  per-requester command (idx packed IDX_W each)
//   req_ready                  one-hot combinational grant
//   clr_all                    start clear sweep (priority over requests)
//   busy, sweep_done           sweep active / one-cycle end pulse
//   flags                      flag bank
//   grant_valid, grant_id      registered report of last accepted command
//   conflict_err               sticky conflict flag (0 when feature off)
module sr_flag_scheduler
  import sr_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  parameter int IDX_W     = $clog2(NUM_FLAGS),
  parameter int PTR_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_set,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     clr_all,
  output logic                     busy,
  output logic                     sweep_done,
  output logic [NUM_FLAGS-1:0]     flags,
  output logic                     grant_valid,
  output logic [PTR_W-1:0]         grant_id,
  output logic                     conflict_err
);

  state_e               state_r, state_next_s;
  logic [PTR_W-1:0]     rr_ptr_r, grant_id_r;
  logic [IDX_W-1:0]     sweep_idx_r;
  logic [NUM_FLAGS-1:0] flags_r;
  logic                 sweep_done_r, grant_valid_r;

  logic [NUM_REQ-1:0]   arb_grant_s;
  logic [PTR_W-1:0]     arb_idx_s;
  logic                 arb_any_s;
  logic                 arb_en_s, accept_s, sweep_last_s, win_set_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic [PTR_W-1:0]     ptr_next_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .any_grant (arb_any_s)
  );

  assign win_idx_s    = req_idx[arb_idx_s*IDX_W +: IDX_W];
  assign win_set_s    = req_set[arb_idx_s];
  assign sweep_last_s = (int'(sweep_idx_r) == NUM_FLAGS - 1);
  assign ptr_next_s   = (int'(arb_idx_s) == NUM_REQ - 1) ? {PTR_W{1'b0}}
                                                         : arb_idx_s + PTR_W'(1);

  // Next-state and arbitration enable; clr_all in IDLE blocks all grants
  always_comb begin
    state_next_s = state_r;
    arb_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_all) begin
          state_next_s = ST_SWEEP;
        end else begin
          arb_en_s = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (sweep_last_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SWEEP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Ready is suppressed during reset so no handshake can be seen that cycle
  assign req_ready = (arb_en_s && !rst) ? arb_grant_s : {NUM_REQ{1'b0}};
  assign accept_s  = arb_en_s && !rst && arb_any_s;

  // State, pointer, flag bank and grant report registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= {PTR_W{1'b0}};
      sweep_idx_r   <= {IDX_W{1'b0}};
      flags_r       <= {NUM_FLAGS{1'b0}};
      sweep_done_r  <= 1'b0;
      grant_valid_r <= 1'b0;
      grant_id_r    <= {PTR_W{1'b0}};
    end else begin
      state_r       <= state_next_s;
      sweep_done_r  <= (state_r == ST_SWEEP) && sweep_last_s;
      grant_valid_r <= accept_s;
      case (state_r)
        ST_IDLE: begin
          sweep_idx_r <= {IDX_W{1'b0}};
          if (accept_s) begin
            rr_ptr_r   <= ptr_next_s;
            grant_id_r <= arb_idx_s;
            // Out-of-range index still handshakes but touches no flag
            if (int'(win_idx_s) < NUM_FLAGS) begin
              flags_r[win_idx_s] <= op_to_level(win_set_s);
            end
          end
        end
        ST_SWEEP: begin
          flags_r[sweep_idx_r] <= 1'b0;
          sweep_idx_r          <= sweep_idx_r + IDX_W'(1);
        end
        default: begin
          sweep_idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign busy        = (state_r == ST_SWEEP);
  assign sweep_done  = sweep_done_r;
  assign flags       = flags_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

`ifdef SR_CONFLICT_DETECT_EN
  logic conflict_s, conflict_err_r;

  // Any pair of valid requesters hitting the same in-range flag with opposite ops
  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (req_valid[i] && req_valid[j] &&
            (req_set[i] != req_set[j]) &&
            (req_idx[i*IDX_W +: IDX_W] == req_idx[j*IDX_W +: IDX_W]) &&
            (int'(req_idx[i*IDX_W +: IDX_W]) < NUM_FLAGS)) begin
          conflict_s = 1'b1;
        end else begin
          conflict_s = conflict_s;
        end
      end
    end
  end

  // Sticky error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_err_r <= 1'b0;
    end else if (conflict_s) begin
      conflict_err_r <= 1'b1;
    end
  end

  assign conflict_err = conflict_err_r;
`else
  assign conflict_err = 1'b0;
`endif

endmodule

// File: doc/sr_flag_scheduler.md
Name: sr_flag_scheduler

Overview:
- Owns a bank of NUM_FLAGS SR-style flag bits and shares write access between NUM_REQ requesters.
- Each request is a set or reset command to one flag index. A round-robin arbiter accepts one command per cycle.
- A clr_all command runs a serialized one-flag-per-cycle clear sweep.
- Sits between software-visible status producers and downstream logic that consumes the flag vector.

Parameters:
- NUM_REQ, 4: number of requesters (>=2).
- NUM_FLAGS, 8: number of flag bits (>=2).
- IDX_W, $clog2(NUM_FLAGS): width of one flag index.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester command valid.
- req_set  input  NUM_REQ  per-requester op: 1 = set (S=1,R=0), 0 = reset (S=0,R=1).
- req_idx  input  NUM_REQ*IDX_W  per-requester flag index, requester i at bits [i*IDX_W +: IDX_W].
- req_ready  output  NUM_REQ  one-hot grant, combinational.
- clr_all  input  1  request full-bank clear sweep.
- busy  output  1  high while sweep active.
- sweep_done  output  1  one-cycle pulse at sweep end.
- flags  output  NUM_FLAGS  current flag bank.
- grant_valid  output  1  registered pulse, cycle after any accepted command.
- grant_id  output  $clog2(NUM_REQ)  requester accepted in the previous cycle.
- conflict_err  output  1  sticky conflict flag (see Optional Feature).

Behaviour:
- Reset: one clock with rst=1 sets the following; rst overrides everything, including mid-sweep.
  - flags=0, rr_ptr=0, state=IDLE.
  - busy=0, sweep_done=0, grant_valid=0, grant_id=0, conflict_err=0.
  - req_ready=0 during the reset cycle.
- FSM states IDLE and SWEEP. busy is registered: busy = (state==SWEEP).
- IDLE, clr_all=0:
  - Winner is the first i with req_valid[i], searching from rr_ptr upward with wrap mod NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle. All other req_ready bits are 0. No valid requests means req_ready=0.
- Transfer occurs when req_valid[i] && req_ready[i]. At that edge:
  - flags[req_idx[i]] <= req_set[i].
  - rr_ptr <= (i+1) mod NUM_REQ.
  - grant_valid <= 1 and grant_id <= i.
- Latency: the flag change is visible one cycle after the handshake. Non-winning requesters must hold valid, set and idx stable until accepted.
- Set on an already-set flag, or reset on an already-clear flag: no change, handshake still completes.
- req_idx >= NUM_FLAGS (non-power-of-2 bank): handshake completes, flags unchanged, rr_ptr advances.
- IDLE, clr_all=1: clr_all has priority. req_ready=0 that cycle. Next state SWEEP with sweep_idx=0.
- SWEEP:
  - Each cycle: flags[sweep_idx] <= 0, sweep_idx++.
  - req_ready=0 throughout. clr_all is ignored. rr_ptr holds.
  - On the cycle sweep_idx==NUM_FLAGS-1: next state IDLE, sweep_done <= 1 for one cycle.
  - Total duration is NUM_FLAGS cycles.
- First grant is possible in the cycle after sweep_done rises, i.e. the cycle busy=0.
- Flags not yet swept retain their value during the sweep.

Optional Feature:
- Macro SR_CONFLICT_DETECT_EN.
- Defined:
  - Each cycle, a conflict exists if any two valid requesters target the same in-range index with opposite req_set. This is the illegal S=R=1 condition.
  - A conflict sets conflict_err at the next edge. It stays set until rst.
  - Detection runs in IDLE and SWEEP. Arbitration is unaffected.
- Undefined: conflict_err tied 0, no detection logic.

Decomposition:
- Package sr_sched_pkg:
  - State enum {ST_IDLE, ST_SWEEP}.
  - Op constants OP_SET=1'b1, OP_RESET=1'b0.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; rr_ptr register stays in the parent.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 -> flags=0, req_ready=0, busy=0, grant_valid=0, conflict_err=0.
- Single op: req0 set idx 3 -> req_ready[0]=1 same cycle; next cycle flags=8'h08, grant_valid=1, grant_id=0. Then req0 reset idx 3 -> flags=8'h00.
- Round-robin fairness: all 4 requesters valid continuously, each setting a distinct idx 0..3 -> accepted in order 0,1,2,3, one per cycle; flags=8'h0F after 4 grants.
- Pointer wrap: with rr_ptr=3, req1 and req3 both valid -> req3 wins, then req1.
- Sweep: flags=8'hFF, pulse clr_all together with req2 valid -> no ready that cycle; busy=1 for 8 cycles, flags clear LSB-first one bit per cycle; sweep_done pulses once; req2 accepted the cycle busy=0.
- Conflict (SR_CONFLICT_DETECT_EN defined): req0 set idx 5 and req1 reset idx 5 in the same cycle -> conflict_err=1 next cycle and stays 1; req0 granted, flags[5]=1. Cleared only by rst.
